odo_sbox_lut_bank: RTL and testbench

//  Runtime-loadable, multi-lane S-box lookup bank for the Odo round pipeline.

---
 rtl/odo_sbox_lut_bank_if.sv | 29 ++
 rtl/odo_sbox_lut_bank.sv | 146 ++++++++++++++
 tb/tb_odo_sbox_lut_bank.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/odo_sbox_lut_bank_if.sv
// Load / lookup / result bundle for the Odo S-box bank.
// The master side is the table loader and requester; the slave side is the bank.
interface odo_sbox_lut_bank_if #(
  parameter int WIDTH = 6,
  parameter int LANES = 4
);
  logic                   load_start;
  logic                   load_valid;
  logic [WIDTH-1:0]       load_data;
  logic                   load_ready;
  logic                   load_done;
  logic                   table_ready;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic                   out_valid;
  logic [LANES*WIDTH-1:0] out_data;
  logic                   perm_err;

  modport master (
    output load_start, load_valid, load_data, in_valid, in_data,
    input  load_ready, load_done, table_ready, in_ready, out_valid, out_data, perm_err
  );

  modport slave (
    input  load_start, load_valid, load_data, in_valid, in_data,
    output load_ready, load_done, table_ready, in_ready, out_valid, out_data, perm_err
  );
endinterface

// File: rtl/odo_sbox_lut_bank.sv
// Runtime-loadable multi-lane S-box table; lookups are gated by a load FSM that drains in-flight work first.
// Optional duplicate-value detection on load is enabled by defining ODO_SBOX_PERM_CHECK_EN.
module odo_sbox_lut_bank #(
  parameter int WIDTH    = 6,
  parameter int LANES    = 4,
  parameter int PIPE_OUT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  odo_sbox_lut_bank_if.slave   sbox
);
  localparam int DEPTH = 1 << WIDTH;

  typedef enum logic [1:0] {S_EMPTY, S_DRAIN, S_LOAD, S_READY} state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic                   load_init;
  logic                   ld_acc;
  logic                   lk_acc;
  logic                   pipe_busy;
  logic [WIDTH-1:0]       mem [DEPTH];
  logic                   rd_vld_q;
  logic [LANES*WIDTH-1:0] rd_dat_q, rd_dat_d;
  logic                   out_vld;
  logic [LANES*WIDTH-1:0] out_dat;

  // A restart request wins over a word presented in the same cycle.
  assign ld_acc = (state_q == S_LOAD) && sbox.load_valid && !sbox.load_start;
  assign lk_acc = (state_q == S_READY) && sbox.in_valid;

  assign sbox.load_ready  = (state_q == S_LOAD);
  assign sbox.table_ready = (state_q == S_READY);
  assign sbox.in_ready    = (state_q == S_READY);
  assign sbox.load_done   = done_q;
  assign sbox.out_valid   = out_vld;
  assign sbox.out_data    = out_dat;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    load_init = 1'b0;
    case (state_q)
      S_EMPTY: if (sbox.load_start) state_d = S_DRAIN;
      S_DRAIN: if (!pipe_busy) begin
        state_d   = S_LOAD;
        load_init = 1'b1;
        cnt_d     = '0;
      end
      S_LOAD: begin
        if (sbox.load_start) begin
          load_init = 1'b1;
          cnt_d     = '0;
        end else if (sbox.load_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == WIDTH'(DEPTH - 1)) begin
            state_d = S_READY;
            done_d  = 1'b1;
          end
        end
      end
      S_READY: if (sbox.load_start) state_d = S_DRAIN;
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Table contents survive reset; they are meaningless until a load completes.
  always_ff @(posedge clk) begin
    if (ld_acc) mem[cnt_q] <= sbox.load_data;
  end

  always_comb begin
    rd_dat_d = rd_dat_q;
    for (int k = 0; k < LANES; k++) begin
      rd_dat_d[k*WIDTH +: WIDTH] = mem[sbox.in_data[k*WIDTH +: WIDTH]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_q <= 1'b0;
      rd_dat_q <= '0;
    end else begin
      rd_vld_q <= lk_acc;
      if (lk_acc) rd_dat_q <= rd_dat_d;
    end
  end

  if (PIPE_OUT != 0) begin : g_pipe
    logic                   out_vld_q;
    logic [LANES*WIDTH-1:0] out_dat_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_vld_q <= 1'b0;
        out_dat_q <= '0;
      end else begin
        out_vld_q <= rd_vld_q;
        if (rd_vld_q) out_dat_q <= rd_dat_q;
      end
    end

    assign out_vld   = out_vld_q;
    assign out_dat   = out_dat_q;
    assign pipe_busy = rd_vld_q | out_vld_q;
  end else begin : g_nopipe
    assign out_vld   = rd_vld_q;
    assign out_dat   = rd_dat_q;
    assign pipe_busy = rd_vld_q;
  end

`ifdef ODO_SBOX_PERM_CHECK_EN
  logic [DEPTH-1:0] seen_q;
  logic             perm_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q     <= '0;
      perm_err_q <= 1'b0;
    end else begin
      if (load_init) seen_q <= '0;
      else if (ld_acc) seen_q[sbox.load_data] <= 1'b1;
      if (sbox.load_start) perm_err_q <= 1'b0;
      else if (ld_acc && seen_q[sbox.load_data]) perm_err_q <= 1'b1;
    end
  end

  assign sbox.perm_err = perm_err_q;
`else
  assign sbox.perm_err = 1'b0;
`endif
endmodule

// File: tb/tb_odo_sbox_lut_bank.sv
// Bench for odo_sbox_lut_bank: a PIPE_OUT=1 and a PIPE_OUT=0 instance share stimulus;
// results are predicted from a table image held in the bench.
module tb_odo_sbox_lut_bank;
  localparam int LAT  = 2;
  localparam int LAT0 = 1;
`ifdef ODO_SBOX_PERM_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [5:0]  ref_tab [64];
  logic [5:0]  ld_tab  [64];
  logic [23:0] req_a   [128];
  logic        vld_a   [128];
  logic [23:0] exp_hold  = '0;
  logic [23:0] exp_hold0 = '0;

  odo_sbox_lut_bank_if #(.WIDTH(6), .LANES(4)) bus ();
  odo_sbox_lut_bank_if #(.WIDTH(6), .LANES(4)) bus0 ();

  odo_sbox_lut_bank #(.WIDTH(6), .LANES(4), .PIPE_OUT(1)) dut (
    .clk(clk), .rst(rst), .sbox(bus.slave));
  odo_sbox_lut_bank #(.WIDTH(6), .LANES(4), .PIPE_OUT(0)) dut0 (
    .clk(clk), .rst(rst), .sbox(bus0.slave));

  assign bus0.load_start = bus.load_start;
  assign bus0.load_valid = bus.load_valid;
  assign bus0.load_data  = bus.load_data;
  assign bus0.in_valid   = bus.in_valid;
  assign bus0.in_data    = bus.in_data;

  function automatic logic [23:0] lookup(input logic [23:0] idx);
    logic [23:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[k*6 +: 6] = ref_tab[idx[k*6 +: 6]];
    return r;
  endfunction

  task automatic do_load(input int n, output int done_cnt, output int got);
    int idx, extra, cyc;
    idx = 0; extra = 0; cyc = 0; done_cnt = 0;
    @(posedge clk); #1 bus.load_start = 1'b1;
    @(posedge clk); #1 bus.load_start = 1'b0;
    while ((idx < n || extra < 3) && cyc < 600) begin
      bus.load_valid = (idx < n) && bus.load_ready && bus0.load_ready;
      bus.load_data  = ld_tab[idx % 64];
      @(posedge clk);
      if (bus.load_valid) idx++;
      else if (idx >= n) extra++;
      #1;
      if (bus.load_done) done_cnt++;
      cyc++;
    end
    bus.load_valid = 1'b0;
    got = idx;
    if (n == 64 && idx == 64) for (int i = 0; i < 64; i++) ref_tab[i] = ld_tab[i];
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.load_ready !== 1'b0) $display("FAIL rst_load_ready got %b want 0", bus.load_ready); else passed++;
    total++; if (bus.load_done !== 1'b0) $display("FAIL rst_load_done got %b want 0", bus.load_done); else passed++;
    total++; if (bus.table_ready !== 1'b0) $display("FAIL rst_table_ready got %b want 0", bus.table_ready); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", bus.in_ready); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.out_data !== 24'h0) $display("FAIL rst_out_data got %h want 0", bus.out_data); else passed++;
    total++; if (bus.perm_err !== 1'b0) $display("FAIL rst_perm_err got %b want 0", bus.perm_err); else passed++;
    total++; if (bus0.out_valid !== 1'b0) $display("FAIL rst_out_valid0 got %b want 0", bus0.out_valid); else passed++;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_no_table();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = 24'($urandom);
      @(negedge clk);
      total++; if (bus.in_ready !== 1'b0) $display("FAIL empty_in_ready cyc %0d got %b want 0", i, bus.in_ready); else passed++;
      total++; if (bus.out_valid !== 1'b0 || bus0.out_valid !== 1'b0)
        $display("FAIL empty_out_valid cyc %0d got %b/%b want 0/0", i, bus.out_valid, bus0.out_valid); else passed++;
    end
    @(posedge clk); #1 bus.in_valid = 1'b0;
  endtask

  task automatic test_lookup();
    int d, g;
    logic [23:0] want;
    for (int i = 0; i < 64; i++) ld_tab[i] = 6'(i) ^ 6'h2a;
    do_load(64, d, g);
    total++; if (d !== 1 || g !== 64) $display("FAIL load_done_pulses got %0d words %0d want 1 / 64", d, g); else passed++;
    total++; if (bus.table_ready !== 1'b1) $display("FAIL load_table_ready got %b want 1", bus.table_ready); else passed++;
    want = {6'h00, 6'h3f, 6'h15, 6'h2a};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.in_valid = (i == 0);
      bus.in_data  = {6'h2a, 6'h15, 6'h3f, 6'h00};
      @(negedge clk);
      if (i == 0) begin
        total++; if (bus.in_ready !== 1'b1) $display("FAIL lookup_in_ready got %b want 1", bus.in_ready); else passed++;
      end
      total++; if (bus.out_valid !== (i == LAT)) $display("FAIL lookup_latency cyc %0d got %b want %b", i, bus.out_valid, i == LAT); else passed++;
      total++; if (bus0.out_valid !== (i == LAT0)) $display("FAIL lookup_latency0 cyc %0d got %b want %b", i, bus0.out_valid, i == LAT0); else passed++;
      if (i == LAT) begin
        total++; if (bus.out_data !== want) $display("FAIL lookup_data got %h want %h", bus.out_data, want); else passed++;
      end
      if (i == LAT0) begin
        total++; if (bus0.out_data !== want) $display("FAIL lookup_data0 got %h want %h", bus0.out_data, want); else passed++;
      end
    end
    bus.in_valid = 1'b0;
    exp_hold = want; exp_hold0 = want;
  endtask

  // Streams n requests; bubbles inserts random idle cycles, otherwise index=i on all lanes.
  task automatic test_stream(input string tag, input int n, input bit bubbles);
    int j;
    logic ev, ev0;
    logic [5:0] ii;
    for (int i = 0; i < n; i++) begin
      ii = 6'(i);
      vld_a[i] = bubbles ? ($urandom_range(3, 0) != 0) : 1'b1;
      req_a[i] = bubbles ? 24'($urandom) : {ii, ii, ii, ii};
    end
    for (int i = 0; i < n + LAT + 2; i++) begin
      @(posedge clk); #1;
      bus.in_valid = (i < n) ? vld_a[i] : 1'b0;
      bus.in_data  = (i < n) ? req_a[i] : 24'h0;
      @(negedge clk);
      j = i - LAT;
      ev = (j >= 0 && j < n) ? vld_a[j] : 1'b0;
      if (ev) exp_hold = lookup(req_a[j]);
      j = i - LAT0;
      ev0 = (j >= 0 && j < n) ? vld_a[j] : 1'b0;
      if (ev0) exp_hold0 = lookup(req_a[j]);
      total++; if (bus.out_valid !== ev) $display("FAIL %s out_valid cyc %0d got %b want %b", tag, i, bus.out_valid, ev); else passed++;
      total++; if (bus.out_data !== exp_hold) $display("FAIL %s out_data cyc %0d got %h want %h", tag, i, bus.out_data, exp_hold); else passed++;
      total++; if (bus0.out_valid !== ev0) $display("FAIL %s out_valid0 cyc %0d got %b want %b", tag, i, bus0.out_valid, ev0); else passed++;
      total++; if (bus0.out_data !== exp_hold0) $display("FAIL %s out_data0 cyc %0d got %h want %h", tag, i, bus0.out_data, exp_hold0); else passed++;
    end
  endtask

  task automatic test_reload_drain();
    int d, g, first_rdy, last_ov, j;
    logic ev;
    first_rdy = -1; last_ov = -1;
    for (int c = 0; c < 12; c++) begin
      req_a[c] = 24'($urandom);
      @(posedge clk); #1;
      bus.in_valid   = 1'b1;
      bus.in_data    = req_a[c];
      bus.load_start = (c == 2);
      @(negedge clk);
      if (c < 3) begin
        total++; if (bus.in_ready !== 1'b1) $display("FAIL drain_in_ready_pre cyc %0d got %b want 1", c, bus.in_ready); else passed++;
      end else begin
        total++; if (bus.in_ready !== 1'b0 || bus.table_ready !== 1'b0)
          $display("FAIL drain_gated cyc %0d got %b/%b want 0/0", c, bus.in_ready, bus.table_ready); else passed++;
      end
      j = c - LAT;
      ev = (j >= 0 && j < 3);
      if (ev) exp_hold = lookup(req_a[j]);
      total++; if (bus.out_valid !== ev) $display("FAIL drain_out_valid cyc %0d got %b want %b", c, bus.out_valid, ev); else passed++;
      total++; if (bus.out_data !== exp_hold) $display("FAIL drain_out_data cyc %0d got %h want %h", c, bus.out_data, exp_hold); else passed++;
      if (bus.out_valid) last_ov = c;
      if (bus.load_ready && first_rdy < 0) first_rdy = c;
    end
    bus.in_valid = 1'b0;
    bus.load_start = 1'b0;
    exp_hold0 = lookup(req_a[2]);
    total++; if (first_rdy < 0 || first_rdy <= last_ov)
      $display("FAIL drain_order load_ready cyc %0d last out_valid cyc %0d want ready after", first_rdy, last_ov); else passed++;
    for (int i = 0; i < 64; i++) ld_tab[i] = ~6'(i);
    do_load(64, d, g);
    total++; if (d !== 1 || g !== 64) $display("FAIL reload_done got %0d words %0d want 1 / 64", d, g); else passed++;
    req_a[0] = {6'($urandom), 6'($urandom), 6'($urandom), 6'h05};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.in_valid = (i == 0);
      bus.in_data  = req_a[0];
      @(negedge clk);
      if (i == LAT) begin
        exp_hold = lookup(req_a[0]);
        total++; if (bus.out_data[5:0] !== 6'h3a) $display("FAIL reload_lane0 got %h want 3a", bus.out_data[5:0]); else passed++;
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_hold)
          $display("FAIL reload_lookup got %b/%h want 1/%h", bus.out_valid, bus.out_data, exp_hold); else passed++;
      end
    end
    bus.in_valid = 1'b0;
    exp_hold0 = lookup(req_a[0]);
  endtask

  task automatic test_reset_mid_load();
    int d, g, r;
    logic [5:0] t;
    for (int i = 0; i < 64; i++) ld_tab[i] = 6'(i);
    for (int i = 63; i > 0; i--) begin
      r = $urandom_range(i, 0);
      t = ld_tab[i]; ld_tab[i] = ld_tab[r]; ld_tab[r] = t;
    end
    do_load(20, d, g);
    total++; if (g !== 20 || d !== 0) $display("FAIL partial_load words %0d done %0d want 20 / 0", g, d); else passed++;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    total++; if (bus.load_ready !== 1'b0 || bus.load_done !== 1'b0 || bus.table_ready !== 1'b0 || bus.in_ready !== 1'b0)
      $display("FAIL midrst_ctrl got %b%b%b%b want 0000", bus.load_ready, bus.load_done, bus.table_ready, bus.in_ready); else passed++;
    total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 24'h0 || bus.perm_err !== 1'b0)
      $display("FAIL midrst_out got %b/%h/%b want 0/0/0", bus.out_valid, bus.out_data, bus.perm_err); else passed++;
    @(posedge clk); #1 rst = 1'b0;
    exp_hold = '0; exp_hold0 = '0;
    for (int i = 0; i < 5; i++) begin
      bus.load_valid = 1'b1;
      @(negedge clk);
      total++; if (bus.load_ready !== 1'b0 || bus.table_ready !== 1'b0)
        $display("FAIL midrst_idle cyc %0d got %b/%b want 0/0", i, bus.load_ready, bus.table_ready); else passed++;
      @(posedge clk); #1;
    end
    bus.load_valid = 1'b0;
    do_load(64, d, g);
    total++; if (d !== 1 || g !== 64 || bus.table_ready !== 1'b1)
      $display("FAIL midrst_reload done %0d words %0d table_ready %b want 1/64/1", d, g, bus.table_ready); else passed++;
  endtask

  task automatic test_perm();
    int idx, cyc, d, g;
    bit seen [64];
    bit err;
    for (int i = 0; i < 64; i++) begin ld_tab[i] = 6'(i); seen[i] = 1'b0; end
    ld_tab[3] = 6'h05; ld_tab[5] = 6'h03; ld_tab[9] = 6'h05;
    err = 1'b0; idx = 0; cyc = 0;
    @(posedge clk); #1 bus.load_start = 1'b1;
    @(posedge clk); #1 bus.load_start = 1'b0;
    while (idx < 64 && cyc < 600) begin
      bus.load_valid = bus.load_ready && bus0.load_ready;
      bus.load_data  = ld_tab[idx];
      @(posedge clk);
      if (bus.load_valid) begin
        if (seen[ld_tab[idx]]) err = 1'b1;
        seen[ld_tab[idx]] = 1'b1;
        idx++;
        #1;
        total++; if (bus.perm_err !== (PCHK && err))
          $display("FAIL perm_err word %0d got %b want %b", idx - 1, bus.perm_err, PCHK && err); else passed++;
      end else #1;
      cyc++;
    end
    bus.load_valid = 1'b0;
    total++; if (idx !== 64) $display("FAIL perm_load words %0d want 64", idx); else passed++;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.perm_err !== PCHK || bus.table_ready !== 1'b1)
      $display("FAIL perm_sticky got %b/%b want %b/1", bus.perm_err, bus.table_ready, PCHK); else passed++;
    bus.load_start = 1'b1;
    @(posedge clk); #1 bus.load_start = 1'b0;
    total++; if (bus.perm_err !== 1'b0) $display("FAIL perm_clear got %b want 0", bus.perm_err); else passed++;
    for (int i = 0; i < 64; i++) ld_tab[i] = 6'(i) ^ 6'h15;
    do_load(64, d, g);
    total++; if (d !== 1 || g !== 64 || bus.perm_err !== 1'b0)
      $display("FAIL perm_clean done %0d words %0d perm_err %b want 1/64/0", d, g, bus.perm_err); else passed++;
  endtask

  initial begin
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    test_reset();
    test_no_table();
    test_lookup();
    test_stream("back_to_back", 64, 1'b0);
    test_stream("random_a", 100, 1'b1);
    test_reload_drain();
    test_stream("random_b", 60, 1'b1);
    test_reset_mid_load();
    test_stream("random_c", 60, 1'b1);
    test_perm();
    test_stream("random_d", 60, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end
endmodule
